// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults and debug encodings for the register file and scoreboard.
package reg_file_sb_pkg;
    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = 5;
    localparam logic [DEF_AW-1:0] REG_ZERO = '0;
    typedef enum logic [1:0] {HZ_NONE, HZ_RAW1, HZ_RAW2, HZ_WAW} hz_kind_e;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_file_sb_scoreboard: in-flight destination tracking and issue hazard detection.
import reg_file_sb_pkg::*;
module reg_file_sb_scoreboard #(
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic            issue_valid,
    input  logic            issue_has_rd,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_uses_rs2,
    output logic            stall,
    output logic            issue_ack,
    output logic [NREG-1:0] busy
);
    logic [NREG-1:0] clr, set, pend;
    hz_kind_e hz;
    always_comb begin
        clr = wb_valid ? (NREG'(1) << wb_rd) : '0;
        pend = busy & ~clr;
        pend[REG_ZERO] = 1'b0;
        hz = pend[rs1] ? HZ_RAW1 :
             (issue_uses_rs2 && pend[rs2]) ? HZ_RAW2 :
             (issue_has_rd && pend[issue_rd]) ? HZ_WAW : HZ_NONE;
        stall = issue_valid && hz != HZ_NONE;
        issue_ack = issue_valid && !stall;
        set = (issue_ack && issue_has_rd && issue_rd != REG_ZERO) ? (NREG'(1) << issue_rd) : '0;
    end
    // Set is OR-ed after the clear so a same-index issue keeps the bit high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else busy <= (busy & ~clr) | set;
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: architectural register file with write-back bypass, retire stats and scoreboard.
import reg_file_sb_pkg::*;
module reg_file_sb #(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            issue_valid_i,
    input  logic            issue_has_rd_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic            issue_uses_rs2_i,
    output logic            stall_o,
    output logic            issue_ack_o,
    output logic [NREG-1:0] busy_o,
    output logic [31:0]     retire_cnt_o,
    output logic [XLEN-1:0] last_pc_o
);
    logic [XLEN-1:0] regs [NREG];
    reg_file_sb_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
        .clk(clk),
        .reset(reset),
        .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_i),
        .rs1(rs1_i),
        .rs2(rs2_i),
        .issue_valid(issue_valid_i),
        .issue_has_rd(issue_has_rd_i),
        .issue_rd(issue_rd_i),
        .issue_uses_rs2(issue_uses_rs2_i),
        .stall(stall_o),
        .issue_ack(issue_ack_o),
        .busy(busy_o)
    );
    always_comb begin
        rs1_data_o = (rs1_i == AW'(REG_ZERO)) ? '0 :
                     (wb_valid_i && wb_rd_i == rs1_i) ? wb_data_i : regs[rs1_i];
        rs2_data_o = (rs2_i == AW'(REG_ZERO)) ? '0 :
                     (wb_valid_i && wb_rd_i == rs2_i) ? wb_data_i : regs[rs2_i];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            retire_cnt_o <= '0;
            last_pc_o <= '0;
        end else if (wb_valid_i) begin
            if (wb_rd_i != AW'(REG_ZERO)) regs[wb_rd_i] <= wb_data_i;
            retire_cnt_o <= retire_cnt_o + 32'd1;
            last_pc_o <= wb_pc_i;
        end
    end
endmodule
